// File: rtl/cp_strip_s2p.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cp_strip_s2p
// Description : Cyclic-prefix strip and serial-to-parallel pack for the OFDM
//               receive path. Skips CP_LEN samples after each start-of-symbol
//               and packs the next N_FFT samples into one wide word. Two
//               ping-pong banks decouple input filling from output hand-off.
//               Optional macro SYM_CNT_EN adds a 16-bit symbol index output.
// Revision    : 1.0 - initial release
// ============================================================================
module cp_strip_s2p #(
   parameter int I_DATA = 16,
   parameter int N_FFT  = 64,
   parameter int CP_LEN = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [I_DATA-1:0]         in_data,
   input  logic                      in_valid,
   input  logic                      in_sof,
   output logic [N_FFT*I_DATA-1:0]   out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      overflow,
   output logic                      align_err
`ifdef SYM_CNT_EN
   ,
   output logic [15:0]               sym_idx
`endif
);

   localparam int               C_CW   = $clog2(N_FFT) + 1;
   localparam logic [C_CW-1:0]  C_CP   = C_CW'(CP_LEN);
   localparam logic [C_CW-1:0]  C_LAST = C_CW'(N_FFT - 1);
   localparam logic [C_CW-1:0]  C_ONE  = C_CW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SKIP    = 2'd1,
      COLLECT = 2'd2
   } state_t;

   state_t                    r_state, w_state_nxt;
   logic [C_CW-1:0]           r_cnt, w_cnt_nxt, w_cnt_inc, w_wr_idx;
   logic                      r_drop, w_drop_nxt;
   logic                      w_wr_en, w_complete, w_ovf_set, w_aln_set, w_restart;
   logic                      w_accept, w_xfer;
   logic [N_FFT*I_DATA-1:0]   r_bank [2];
   logic [1:0]                r_full;
   logic                      r_wr_bank, r_rd_bank;

   assign w_accept  = enable && in_valid;
   assign w_xfer    = out_valid && out_ready;
   assign w_cnt_inc = r_cnt + C_ONE;
   assign out_valid = r_full[r_rd_bank];
   assign out_data  = r_bank[r_rd_bank];

   // Next-state, counter and bank-write decisions for the accepted sample
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_drop_nxt  = r_drop;
      w_wr_en     = 1'b0;
      w_wr_idx    = r_cnt;
      w_complete  = 1'b0;
      w_ovf_set   = 1'b0;
      w_aln_set   = 1'b0;
      w_restart   = 1'b0;
      if (w_accept) begin
         case (r_state)
            IDLE: begin
               if (in_sof) w_restart = 1'b1;
            end
            SKIP: begin
               if (in_sof) begin
                  w_aln_set = 1'b1;
                  w_restart = 1'b1;
               end else if (w_cnt_inc == C_CP) begin
                  w_state_nxt = COLLECT;
                  w_cnt_nxt   = '0;
                  w_drop_nxt  = r_full[r_wr_bank];
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            COLLECT: begin
               if (in_sof) begin
                  w_aln_set = 1'b1;
                  w_restart = 1'b1;
               end else begin
                  if (r_drop) w_ovf_set = 1'b1;
                  else        w_wr_en   = 1'b1;
                  if (r_cnt == C_LAST) begin
                     w_complete  = !r_drop;
                     w_state_nxt = IDLE;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
         // A start-of-symbol always restarts from the IDLE behaviour,
         // abandoning any partial symbol (its bank is never marked full).
         if (w_restart) begin
            if (CP_LEN == 0) begin
               w_state_nxt = COLLECT;
               w_cnt_nxt   = C_ONE;
               w_drop_nxt  = r_full[r_wr_bank];
               w_wr_idx    = '0;
               if (r_full[r_wr_bank]) w_ovf_set = 1'b1;
               else                   w_wr_en   = 1'b1;
            end else if (CP_LEN == 1) begin
               w_state_nxt = COLLECT;
               w_cnt_nxt   = '0;
               w_drop_nxt  = r_full[r_wr_bank];
            end else begin
               w_state_nxt = SKIP;
               w_cnt_nxt   = C_ONE;
            end
         end
      end
   end

   // FSM state, sample counter and drop flag for the symbol in progress
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   // Ping-pong banks: write side fills wr_bank, read side releases rd_bank.
   // A write and a release never target the same bank in one cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bank[0] <= '0;
         r_bank[1] <= '0;
         r_full    <= 2'b00;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
      end else begin
         if (w_wr_en) r_bank[r_wr_bank][w_wr_idx*I_DATA +: I_DATA] <= in_data;
         if (w_complete) begin
            r_full[r_wr_bank] <= 1'b1;
            r_wr_bank         <= ~r_wr_bank;
         end
         if (w_xfer) begin
            r_full[r_rd_bank] <= 1'b0;
            r_bank[r_rd_bank] <= '0;
            r_rd_bank         <= ~r_rd_bank;
         end
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow  <= 1'b0;
         align_err <= 1'b0;
      end else begin
         if (w_ovf_set) overflow  <= 1'b1;
         if (w_aln_set) align_err <= 1'b1;
      end
   end

`ifdef SYM_CNT_EN
   // Index of the symbol presented on out_data; advances on each hand-off
   always_ff @(posedge clk) begin
      if (!reset)      sym_idx <= 16'd0;
      else if (w_xfer) sym_idx <= sym_idx + 16'd1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cp_strip_s2p.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cp_strip_s2p
// Description : Self-checking bench for cp_strip_s2p. Instance u_dut1 uses
//               N_FFT=8/CP_LEN=2, instance u_dut2 uses N_FFT=4/CP_LEN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp_strip_s2p;

   localparam int W  = 16;
   localparam int N1 = 8;
   localparam int N2 = 4;

   logic            clk       = 1'b0;
   logic            reset     = 1'b0;
   logic            enable    = 1'b0;
   logic [W-1:0]    in_data   = '0;
   logic            in_valid  = 1'b0;
   logic            in_sof    = 1'b0;
   logic            out_ready = 1'b0;

   logic [N1*W-1:0] out_data1;
   logic            out_valid1, overflow1, align_err1;
   logic [N2*W-1:0] out_data2;
   logic            out_valid2, overflow2, align_err2;
`ifdef SYM_CNT_EN
   logic [15:0]     sym_idx1, sym_idx2;
`endif

   int errors = 0;
   int checks = 0;

   cp_strip_s2p #(.I_DATA(W), .N_FFT(N1), .CP_LEN(2)) u_dut1 (
      .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
      .in_valid(in_valid), .in_sof(in_sof), .out_data(out_data1),
      .out_valid(out_valid1), .out_ready(out_ready), .overflow(overflow1),
      .align_err(align_err1)
`ifdef SYM_CNT_EN
      , .sym_idx(sym_idx1)
`endif
   );

   cp_strip_s2p #(.I_DATA(W), .N_FFT(N2), .CP_LEN(0)) u_dut2 (
      .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
      .in_valid(in_valid), .in_sof(in_sof), .out_data(out_data2),
      .out_valid(out_valid2), .out_ready(out_ready), .overflow(overflow2),
      .align_err(align_err2)
`ifdef SYM_CNT_EN
      , .sym_idx(sym_idx2)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         vld;
      logic         sof;
      logic [W-1:0] d;
      logic         ev;   // expected out_valid after the edge
      logic         cd;   // compare out_data against ramp 2..9
   } vec_t;

   vec_t t1 [11];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic sof, input logic [W-1:0] d);
      enable   = 1'b1;
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = d;
      step();
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_sym(input int base, input int n);
      for (int i = 0; i < n; i++) send(i == 0, W'(base + i));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   function automatic logic [127:0] ramp(input int base);
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < N1; k++) v[k*W +: W] = W'(base + k);
      return v;
   endfunction

   initial begin
      // reset state
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      chk("rst_valid", out_valid1, 1'b0);
      chk("rst_data",  out_data1,  '0);
      chk("rst_ovf",   overflow1,  1'b0);
      chk("rst_aln",   align_err1, 1'b0);

      // 1: single symbol, table-driven cycle by cycle
      for (int i = 0; i < 10; i++) t1[i] = '{1'b1, (i == 0), W'(i), (i == 9), (i == 9)};
      t1[10] = '{1'b0, 1'b0, '0, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         enable   = 1'b1;
         in_valid = t1[i].vld;
         in_sof   = t1[i].sof;
         in_data  = t1[i].d;
         step();
         chk($sformatf("t1_valid[%0d]", i), out_valid1, t1[i].ev);
         if (t1[i].cd) chk("t1_data", out_data1, ramp(2));
      end
      in_valid = 1'b0;

      // 2: back-to-back symbols held, third symbol overflows
      do_reset();
      out_ready = 1'b0;
      send_sym(0, 10);
      send_sym(100, 10);
      chk("t2_data_a", out_data1, ramp(2));
      step(); step(); step();
      chk("t2_hold_valid", out_valid1, 1'b1);
      chk("t2_hold_data",  out_data1,  ramp(2));
      chk("t2_no_ovf_yet", overflow1,  1'b0);
      send_sym(200, 10);
      chk("t2_ovf",        overflow1,  1'b1);
      chk("t2_data_a2",    out_data1,  ramp(2));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t2_valid_b",    out_valid1, 1'b1);
      chk("t2_data_b",     out_data1,  ramp(102));
      step();
      chk("t2_data_b_hold", out_data1, ramp(102));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t2_empty",      out_valid1, 1'b0);

      // 5: reset with one bank full and a symbol mid-COLLECT
      send_sym(300, 10);
      chk("t5_full", out_valid1, 1'b1);
      for (int i = 0; i < 5; i++) send(i == 0, W'(400 + i));
      do_reset();
      chk("t5_valid", out_valid1, 1'b0);
      chk("t5_data",  out_data1,  '0);
      chk("t5_ovf",   overflow1,  1'b0);
      chk("t5_aln",   align_err1, 1'b0);
      out_ready = 1'b1;
      send_sym(500, 10);
      chk("t5_fresh_valid", out_valid1, 1'b1);
      chk("t5_fresh_data",  out_data1,  ramp(502));
      step();

      // 3: early start-of-symbol abandons the partial symbol
      do_reset();
      out_ready = 1'b1;
      send_sym(0, 5);
      chk("t3_aln_pre", align_err1, 1'b0);
      send_sym(50, 10);
      chk("t3_aln",   align_err1, 1'b1);
      chk("t3_valid", out_valid1, 1'b1);
      chk("t3_data",  out_data1,  ramp(52));
      step();
      chk("t3_single", out_valid1, 1'b0);

      // 4: enable low mid-COLLECT with junk on the input
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(i == 0, W'(i));
      for (int i = 0; i < 3; i++) begin
         enable   = 1'b0;
         in_valid = 1'b1;
         in_sof   = (i == 1);
         in_data  = 16'h7FFF;
         step();
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("t4_gap_valid", out_valid1, 1'b0);
      for (int i = 5; i < 10; i++) send(1'b0, W'(i));
      chk("t4_valid", out_valid1, 1'b1);
      chk("t4_data",  out_data1,  ramp(2));
      chk("t4_aln",   align_err1, 1'b0);
      step();

      // 6: CP_LEN=0, N_FFT=4, signed extremes
      do_reset();
      out_ready = 1'b0;
      send(1'b1, 16'h0008);
      send(1'b0, 16'hFFF8);
      send(1'b0, 16'h7FFF);
      send(1'b0, 16'h8000);
      chk("t6_valid", out_valid2, 1'b1);
      chk("t6_data",  out_data2,  64'h8000_7FFF_FFF8_0008);
      chk("t6_ovf",   overflow2,  1'b0);
`ifdef SYM_CNT_EN
      chk("t6_idx0",  sym_idx2,   16'd0);
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t6_after", out_valid2, 1'b0);
`ifdef SYM_CNT_EN
      chk("t6_idx1",  sym_idx2,   16'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
